probe_sampler: RTL and testbench

- Upstream conditioning stage for the debug probe's hex display.
- Synchronises the raw 8-bit probe bus and a probe strobe into the CLK_100MHz domain, then captures bytes live, on strobe edges, or single-shot.
- Holds the captured byte steady so the 7-segment display stage can show a readable value; its DataOut drives the display byte directly.
- Also counts capture events for the LED bank.

---
 rtl/probe_pkg.sv | 28 ++
 rtl/probe_sync.sv | 27 ++
 rtl/probe_sampler.sv | 194 +++++++++++++++++++
 tb/tb_probe_sampler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/probe_pkg.sv
// Shared encodings and defaults for the probe sampler: capture modes,
// single-shot FSM states and a small edge-detect helper.
package probe_pkg;

  typedef enum logic [1:0] {
    MODE_LIVE   = 2'd0,
    MODE_RISE   = 2'd1,
    MODE_FALL   = 2'd2,
    MODE_SINGLE = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // 100 ms live-update period at 100 MHz
  localparam int HOLD_CYCLES_DEFAULT = 10_000_000;
  localparam int SYNC_STAGES_DEFAULT = 2;
  localparam int CNT_WIDTH_DEFAULT   = 8;

  // A falling edge is a rising edge with the operands swapped.
  function automatic logic rising(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/probe_sync.sv
// WIDTH-bit multi-flop synchroniser; every bit sees the same depth, so
// buses sent through one instance stay aligned with each other.
module probe_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  // NOTE: sequential state is written with non-blocking assignments so every
  // stage samples its predecessor's pre-edge value, forming a true shift chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/probe_sampler.sv
// Probe conditioning stage: synchronises the raw probe bus, captures bytes
// live / on strobe edges / single-shot, and counts strobe captures.
module probe_sampler
  import probe_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEFAULT
) (
  input  logic                 CLK_100MHz,
  input  logic                 Reset,
  input  logic [7:0]           DataIn,
  input  logic                 StrobeIn,
  input  logic [1:0]           Mode,
  input  logic                 Arm,
  input  logic                 Clear,
  output logic [7:0]           DataOut,
  output logic [CNT_WIDTH-1:0] EventCount,
  output logic                 Saturated,
  output logic                 ArmedOut,
  output logic                 DoneOut
);

  localparam int                    HOLD_W      = $clog2(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0]     HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX     = '1;

  // NOTE: reset asserts asynchronously but releases on a clock edge through
  // this 2-FF synchroniser, so no flop sees a release near its sampling edge.
  logic [1:0] rst_sync;
  logic       rst;

  always_ff @(posedge CLK_100MHz or posedge Reset) begin
    if (Reset) begin
      rst_sync <= 2'b11;
    end else begin
      rst_sync <= {rst_sync[0], 1'b0};
    end
  end

  assign rst = rst_sync[1];

  // Input chains clear on the raw reset and refill while the internal reset
  // is still held, so live data is valid on the first released clock.
  logic [8:0] bus_sync;
  logic [1:0] ctl_sync;
  logic [7:0] sync_data;
  logic       sync_strobe;
  logic       sync_arm;
  logic       sync_clear;

  probe_sync #(.WIDTH(9), .STAGES(SYNC_STAGES)) u_sync_bus (
    .clk (CLK_100MHz),
    .rst (Reset),
    .d   ({StrobeIn, DataIn}),
    .q   (bus_sync)
  );

  probe_sync #(.WIDTH(2), .STAGES(SYNC_STAGES)) u_sync_ctl (
    .clk (CLK_100MHz),
    .rst (Reset),
    .d   ({Clear, Arm}),
    .q   (ctl_sync)
  );

  assign {sync_strobe, sync_data} = bus_sync;
  assign {sync_clear, sync_arm}   = ctl_sync;

  // Registered edge flags, with the data byte captured alongside the strobe
  // edge so a capture always uses the byte that arrived with that edge.
  logic       strobe_d, arm_d, clear_d;
  logic       rise_e, fall_e, arm_e, clear_e;
  logic [7:0] edge_data;

  always_ff @(posedge CLK_100MHz or posedge rst) begin
    if (rst) begin
      strobe_d  <= 1'b0;
      arm_d     <= 1'b0;
      clear_d   <= 1'b0;
      rise_e    <= 1'b0;
      fall_e    <= 1'b0;
      arm_e     <= 1'b0;
      clear_e   <= 1'b0;
      edge_data <= 8'h00;
    end else begin
      strobe_d  <= sync_strobe;
      arm_d     <= sync_arm;
      clear_d   <= sync_clear;
      rise_e    <= rising(sync_strobe, strobe_d);
      fall_e    <= rising(strobe_d, sync_strobe);
      arm_e     <= rising(sync_arm, arm_d);
      clear_e   <= rising(sync_clear, clear_d);
      edge_data <= sync_data;
    end
  end

  mode_e mode_q, mode_prev;
  logic  mode_change;

  always_ff @(posedge CLK_100MHz or posedge rst) begin
    if (rst) begin
      mode_q    <= MODE_LIVE;
      mode_prev <= MODE_LIVE;
    end else begin
      mode_q    <= mode_e'(Mode);
      mode_prev <= mode_q;
    end
  end

  assign mode_change = (mode_q != mode_prev);

  // Single-shot FSM: state register, next-state logic, output decode.
  state_e            state, next_state;
  logic              capture;
  logic              live_load;
  logic [HOLD_W-1:0] hold_cnt;

  always_ff @(posedge CLK_100MHz or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ArmedOut <= 1'b0;
      DoneOut  <= 1'b0;
    end else begin
      state    <= next_state;
      ArmedOut <= (next_state == S_ARMED);
      DoneOut  <= (next_state == S_DONE);
    end
  end

  // NOTE: every always_comb output gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    if (mode_change || mode_q != MODE_SINGLE) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (arm_e)  next_state = S_ARMED;
        S_ARMED: if (rise_e) next_state = S_DONE;
        S_DONE:  if (arm_e)  next_state = S_ARMED;
        default: next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    capture   = 1'b0;
    live_load = 1'b0;
    if (!mode_change) begin
      case (mode_q)
        MODE_LIVE:   live_load = (hold_cnt == '0);
        MODE_RISE:   capture   = rise_e;
        MODE_FALL:   capture   = fall_e;
        MODE_SINGLE: capture   = (state == S_ARMED) && rise_e;
        default:     capture   = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK_100MHz or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (mode_change) begin
      hold_cnt <= '0;
    end else if (mode_q == MODE_LIVE) begin
      hold_cnt <= (hold_cnt == '0) ? HOLD_RELOAD : hold_cnt - HOLD_W'(1);
    end
  end

  always_ff @(posedge CLK_100MHz or posedge rst) begin
    if (rst) begin
      DataOut <= 8'h00;
    end else if (live_load) begin
      DataOut <= sync_data;
    end else if (capture) begin
      DataOut <= edge_data;
    end
  end

  // Clear beats a same-cycle increment; the byte capture above is unaffected.
  always_ff @(posedge CLK_100MHz or posedge rst) begin
    if (rst) begin
      EventCount <= '0;
      Saturated  <= 1'b0;
    end else if (clear_e && !mode_change) begin
      EventCount <= '0;
      Saturated  <= 1'b0;
    end else if (capture && EventCount != CNT_MAX) begin
      EventCount <= EventCount + CNT_WIDTH'(1);
      Saturated  <= (EventCount == CNT_MAX - CNT_WIDTH'(1));
    end
  end

endmodule

// File: tb/tb_probe_sampler.sv
// Directed bench for probe_sampler: expected byte/count/flag are queued when a
// strobe is driven and compared once the capture latency has elapsed.
module tb_probe_sampler;

  localparam int HOLD = 10;

  logic       clk = 1'b0;
  logic       Reset;
  logic [7:0] DataIn;
  logic       StrobeIn;
  logic [1:0] Mode;
  logic       Arm;
  logic       Clear;
  logic [7:0] DataOut;
  logic [7:0] EventCount;
  logic       Saturated;
  logic       ArmedOut;
  logic       DoneOut;

  probe_sampler #(.SYNC_STAGES(2), .HOLD_CYCLES(HOLD), .CNT_WIDTH(8)) dut (
    .CLK_100MHz (clk),
    .Reset      (Reset),
    .DataIn     (DataIn),
    .StrobeIn   (StrobeIn),
    .Mode       (Mode),
    .Arm        (Arm),
    .Clear      (Clear),
    .DataOut    (DataOut),
    .EventCount (EventCount),
    .Saturated  (Saturated),
    .ArmedOut   (ArmedOut),
    .DoneOut    (DoneOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] data;
    logic [7:0] cnt;
    logic       sat;
  } exp_t;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         exp_cnt = 0;
  logic [7:0] exp_data = 8'h00;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [7:0] d, input logic captures);
    exp_t e;
    if (captures) begin
      exp_data = d;
      exp_cnt  = (exp_cnt < 255) ? exp_cnt + 1 : 255;
    end
    e.tag  = tag;
    e.data = exp_data;
    e.cnt  = 8'(exp_cnt);
    e.sat  = (exp_cnt == 255);
    sb.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL sb_empty: observed no entry expected one");
    end else begin
      e = sb.pop_front();
      check(e.tag, {15'd0, DataOut, EventCount, Saturated}, {15'd0, e.data, e.cnt, e.sat});
    end
  endtask

  // One strobe pulse: rising edge sampled at the first edge, falling at the
  // next; four more clocks cover the 3-clock capture latency of either edge.
  task automatic pulse(input string tag, input logic [7:0] d, input logic captures);
    sb_push(tag, d, captures);
    DataIn   = d;
    StrobeIn = 1'b1;
    tick();
    StrobeIn = 1'b0;
    tick(4);
    sb_check();
  endtask

  task automatic arm_edge();
    Arm = 1'b1;
    tick(4);
    Arm = 1'b0;
    tick();
  endtask

  task automatic set_mode(input logic [1:0] m);
    Mode = m;
    tick(4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset    = 1'b1;
    DataIn   = 8'hA5;
    StrobeIn = 1'b0;
    Mode     = 2'd0;
    Arm      = 1'b0;
    Clear    = 1'b0;
    tick(3);
    check("rst_data",  32'(DataOut),    32'h00);
    check("rst_cnt",   32'(EventCount), 32'h00);
    check("rst_sat",   32'(Saturated),  32'h0);
    check("rst_armed", 32'(ArmedOut),   32'h0);
    check("rst_done",  32'(DoneOut),    32'h0);

    // LIVE: internal reset releases two clocks after Reset falls
    Reset = 1'b0;
    tick(2);
    check("live_pre", 32'(DataOut), 32'h00);
    tick();
    check("live_first", 32'(DataOut), 32'hA5);
    DataIn = 8'h3C;
    tick(HOLD - 1);
    check("live_hold", 32'(DataOut), 32'hA5);
    tick();
    check("live_update", 32'(DataOut), 32'h3C);
    check("live_cnt", 32'(EventCount), 32'h00);
    exp_data = 8'h3C;

    // RISE: exact 3-clock latency from the sampling edge
    DataIn = 8'h5A;
    set_mode(2'd1);
    check("mode_retain", 32'(DataOut), 32'h3C);
    sb_push("rise_capture", 8'h5A, 1'b1);
    StrobeIn = 1'b1;
    tick(3);
    check("rise_early", 32'(DataOut), 32'h3C);
    tick();
    sb_check();
    DataIn = 8'h77;
    tick(2);
    sb_push("rise_no_fall", 8'h77, 1'b0);
    StrobeIn = 1'b0;
    tick(6);
    sb_check();

    // FALL: clear first, then run the counter into saturation
    set_mode(2'd2);
    Clear = 1'b1;
    tick(4);
    check("pre_clear_cnt", 32'(EventCount), 32'h00);
    Clear = 1'b0;
    tick();
    exp_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      pulse("fall_pulse", 8'(i + 3), 1'b1);
    end
    check("fall_sat_cnt",  32'(EventCount), 32'hFF);
    check("fall_sat_flag", 32'(Saturated),  32'h1);
    Clear = 1'b1;
    tick(4);
    check("clear_cnt",  32'(EventCount), 32'h00);
    check("clear_sat",  32'(Saturated),  32'h0);
    check("clear_keep", 32'(DataOut),    32'(exp_data));
    Clear = 1'b0;
    tick();
    exp_cnt = 0;

    // SINGLE
    set_mode(2'd3);
    check("single_idle", 32'({ArmedOut, DoneOut}), 32'h0);
    arm_edge();
    check("single_armed", 32'({ArmedOut, DoneOut}), 32'h2);
    pulse("single_capture", 8'h11, 1'b1);
    check("single_done", 32'({ArmedOut, DoneOut}), 32'h1);
    pulse("single_frozen", 8'h22, 1'b0);
    arm_edge();
    check("single_rearm", 32'({ArmedOut, DoneOut}), 32'h2);
    pulse("single_capture2", 8'h33, 1'b1);
    check("single_done2", 32'({ArmedOut, DoneOut}), 32'h1);

    // Arm and strobe edges in the same synced cycle from DONE
    sb_push("simul_no_capture", 8'h44, 1'b0);
    DataIn   = 8'h44;
    Arm      = 1'b1;
    StrobeIn = 1'b1;
    tick(4);
    check("simul_armed", 32'({ArmedOut, DoneOut}), 32'h2);
    sb_check();
    Arm      = 1'b0;
    StrobeIn = 1'b0;
    tick(4);
    check("simul_stay", 32'({ArmedOut, DoneOut}), 32'h2);

    // Asynchronous reset while ARMED, checked before the next clock edge
    #3;
    Reset  = 1'b1;
    DataIn = 8'h00;
    #1;
    check("async_data", 32'(DataOut),    32'h00);
    check("async_cnt",  32'(EventCount), 32'h00);
    check("async_flags", 32'({Saturated, ArmedOut, DoneOut}), 32'h0);
    tick(3);
    Reset = 1'b0;
    tick(8);
    exp_cnt  = 0;
    exp_data = 8'h00;
    check("post_reset", 32'({DataOut, ArmedOut, DoneOut}), 32'h0);

    // Mode change SINGLE -> RISE -> SINGLE drops the FSM to IDLE
    arm_edge();
    check("pre_change_armed", 32'(ArmedOut), 32'h1);
    set_mode(2'd1);
    check("change_idle", 32'(ArmedOut), 32'h0);
    pulse("mode_rise", 8'h66, 1'b1);
    set_mode(2'd3);
    check("back_idle", 32'({ArmedOut, DoneOut}), 32'h0);
    check("back_retain", 32'(DataOut), 32'h66);
    pulse("idle_no_capture", 8'h55, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
